seq_divider: RTL

Multi-cycle restoring integer divider for the datapath: it undoes, bit by bit, what the ripple adder chain builds up. It takes a dividend and a divisor, runs one trial subtract per clock, and returns quotient and remainder through a start/busy/done handshake. It sits beside the single-cycle ALU as the DIV/DIVU/REM/REMU execution unit. The control path stalls on `busy`.

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_step.sv | 33 +++
 rtl/seq_divider.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   state_t            : controller states (IDLE, CALC, FIX, DONE)
//   DIV_WIDTH_DEFAULT  : default operand/result width
//   DIV_CNT_W_DEFAULT  : iteration counter width at the default width
//   cnt_width()        : iteration counter width for any operand width
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT);

    // The counter only has to reach width-1, so $clog2(width) bits suffice.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   rem_in   : partial remainder before this step (always < divisor)
//   bit_in   : next dividend bit shifted into the remainder
//   divisor  : divisor magnitude
//   rem_out  : partial remainder after the trial subtract / restore
//   q_bit    : quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Because the incoming remainder is below the divisor, the shifted value
    // is below twice the divisor, so a WIDTH+1-bit difference is enough and
    // its top bit acts as the sign of the trial subtract.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring integer divider (DIV/DIVU/REM/REMU), one trial
// subtract per clock, fixed latency of WIDTH+1 cycles from the accepting edge.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request a division (only looked at in IDLE)
//   is_signed    : 1 = two's-complement operands, 0 = unsigned
//   dividend     : dividend, captured with start
//   divisor      : divisor, captured with start
//   busy         : high while a division is in flight (CALC, FIX, DONE)
//   done         : one-cycle pulse, results valid
//   quotient     : registered quotient
//   remainder    : registered remainder
//   div_by_zero  : registered divide-by-zero flag, valid with done
// ---------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] raw_dividend;
    logic             q_neg;
    logic             r_neg;
    logic             dbz;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic             last_iter;

    // Operand magnitudes at accept time. The most-negative value negates to
    // itself, which read as unsigned is exactly its magnitude, so signed
    // overflow falls out of the normal path.
    always_comb begin
        dividend_neg = is_signed & dividend[WIDTH-1];
        divisor_neg  = is_signed & divisor[WIDTH-1];
        dividend_mag = dividend_neg ? (-dividend) : dividend;
        divisor_mag  = divisor_neg  ? (-divisor)  : divisor;
    end

    assign last_iter = (count == CNT_W'(WIDTH - 1));

    // quo_reg doubles as the dividend shift register: its MSB feeds the step
    // and the new quotient bit enters at the LSB.
    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_reg),
        .bit_in  (quo_reg[WIDTH-1]),
        .divisor (divisor_reg),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; CALC lasts exactly WIDTH cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_iter) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Datapath: capture on accept, iterate in CALC, sign-fix and publish in
    // FIX. Results hold until the next FIX; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            divisor_reg  <= '0;
            raw_dividend <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            dbz          <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count        <= '0;
                        rem_reg      <= '0;
                        quo_reg      <= dividend_mag;
                        divisor_reg  <= divisor_mag;
                        raw_dividend <= dividend;
                        q_neg        <= dividend_neg ^ divisor_neg;
                        r_neg        <= dividend_neg;
                        dbz          <= (divisor == '0);
                    end
                end
                CALC: begin
                    rem_reg <= step_rem;
                    quo_reg <= {quo_reg[WIDTH-2:0], step_bit};
                    count   <= last_iter ? '0 : (count + CNT_W'(1));
                end
                FIX: begin
                    div_by_zero <= dbz;
                    if (dbz) begin
                        quotient  <= '1;
                        remainder <= raw_dividend;
                    end else begin
                        quotient  <= q_neg ? (-quo_reg) : quo_reg;
                        remainder <= r_neg ? (-rem_reg) : rem_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
